flit_reader: RTL and testbench
==============================

FLIT_READER -- requirements
Module: flit_reader

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 128, the width of one flit in bits.
REQ-002 SHALL have parameter FLITS, default 5, the flits per packet; legal range 2..16.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous active-high reset.
REQ-005 SHALL have port wr_en  input  1  upstream write strobe, one flit per cycle.
REQ-006 SHALL have port data_in  input  FLIT_WIDTH  flit to store.
REQ-007 SHALL have port wr_ready  output  1  high when a write is accepted.
REQ-008 SHALL have port wr_drop  output  1  one-cycle pulse when a write is rejected.
REQ-009 SHALL have port out_valid  output  1  a flit is presented downstream.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the flit.
REQ-011 SHALL have port data_out  output  FLIT_WIDTH  presented flit.
REQ-012 SHALL have port out_head  output  1  the presented flit is flit 0 of its packet.
REQ-013 SHALL have port out_tail  output  1  the presented flit is flit FLITS-1 of its packet.

Function
REQ-014 SHALL hold a FLITS-entry buffer, a write pointer wr_ptr, a read pointer rd_ptr, and a two-state FSM: FILL and SEND.
REQ-015 In FILL: wr_ready=1 and out_valid=0; wr_en stores data_in at buffer[wr_ptr] and increments wr_ptr.
REQ-016 The write at wr_ptr=FLITS-1 SHALL wrap wr_ptr to 0 and move the FSM to SEND; out_valid rises on the next cycle (latency 1).
REQ-017 In SEND: wr_ready=0 and out_valid=1; data_out=buffer[rd_ptr].
REQ-018 data_out, out_head and out_tail SHALL be decoded from the state and rd_ptr, with no extra register stage.
REQ-019 out_head SHALL be (rd_ptr==0), out_tail SHALL be (rd_ptr==FLITS-1), both gated by out_valid.
REQ-020 A transfer SHALL occur when out_valid and out_ready are both high; on a transfer rd_ptr increments.
REQ-021 The tail transfer SHALL wrap rd_ptr to 0 and return the FSM to FILL; wr_ready rises on the next cycle.
REQ-022 While out_ready=0 in SEND, data_out, out_head, out_tail and out_valid SHALL stay stable.
REQ-023 wr_en while wr_ready=0 SHALL not modify the buffer or pointers and SHALL produce wr_drop=1 in the following cycle.
REQ-024 data_out SHALL be all-zero whenever out_valid=0.
REQ-025 Back-to-back packets: with wr_en continuous and out_ready continuous, each packet SHALL take FLITS cycles to fill and FLITS cycles to send, with no idle cycles between them.

Reset
REQ-026 While rst_in=1 and after its release, the outputs SHALL be:
  - FSM=FILL, wr_ptr=0, rd_ptr=0, buffer all-zero;
  - wr_ready=1;
  - wr_drop=0, out_valid=0, out_head=0, out_tail=0, data_out=0.
REQ-027 Reset asserted mid-FILL or mid-SEND SHALL discard the partial packet immediately, without waiting for a clock edge.

Configuration
REQ-028 The feature macro SHALL be named FLIT_PARITY_EN.
REQ-029 With FLIT_PARITY_EN defined:
  - the block SHALL add output out_parity, 1 bit, equal to the even parity (XOR reduction) of data_out;
  - out_parity SHALL be 0 when out_valid=0 and during reset.
REQ-030 With FLIT_PARITY_EN undefined, out_parity SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover these directed scenarios (FLITS=5, FLIT_WIDTH=128):
  - Reset, then write 1,2,3,4,5 on consecutive cycles with out_ready=1 -> out_valid rises the cycle after the write of 5; data_out is 1..5 on five consecutive cycles; out_head only with 1; out_tail only with 5; wr_ready returns to 1 the cycle after the transfer of 5.
  - Fill with A0..A4, hold out_ready=0 for 3 cycles -> data_out=A0 with out_head=1 held stable; the transfer occurs on the cycle out_ready rises.
  - Issue wr_en with data 0xFF during SEND -> wr_drop=1 for exactly one cycle, and the sent packet is unchanged.
  - Write 3 flits, pulse rst_in, then write 10..14 -> the output packet is 10..14 only, with out_head on 10.
  - Run two back-to-back packets with out_ready toggling 1,0,1,0 -> all 10 flits are delivered in order, with head/tail flags correct per packet.
  - With FLIT_PARITY_EN defined, send a flit 0x...0007 -> out_parity=1; send a flit 0x...0003 -> out_parity=0.

Source files
------------

// File: rtl/flit_reader.sv
// flit_reader: collects one packet of FLITS flits from an upstream writer,
// then presents the stored packet downstream one flit per accepted transfer.
// Writing and sending alternate: while a packet is being sent, writes are
// rejected and reported on wr_drop in the following cycle.
//
// Optional feature macro: FLIT_PARITY_EN (adds out_parity, XOR of data_out).
//
// Ports
//   clk_in      : clock, all state changes on the rising edge
//   rst_in      : asynchronous active-high reset
//   wr_en       : upstream write strobe, one flit per cycle
//   data_in     : flit to store
//   wr_ready    : high while writes are accepted (FILL)
//   wr_drop     : one-cycle pulse, the previous cycle's write was rejected
//   out_valid   : a flit is presented downstream (SEND)
//   out_ready   : downstream accepts the presented flit
//   data_out    : presented flit, zero while out_valid is low
//   out_head    : presented flit is flit 0 of the packet
//   out_parity  : (FLIT_PARITY_EN only) even parity of data_out
//   out_tail    : presented flit is flit FLITS-1 of the packet
module flit_reader #(
  parameter int FLIT_WIDTH = 128,
  parameter int FLITS      = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  wr_en,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  wr_ready,
  output logic                  wr_drop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  out_head,
`ifdef FLIT_PARITY_EN
  output logic                  out_parity,
`endif
  output logic                  out_tail
);

  localparam int            PW   = $clog2(FLITS);
  localparam logic [PW-1:0] LAST = PW'(FLITS - 1);

  typedef enum logic {FILL, SEND} state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]           rd_ptr, rd_ptr_nxt;
  logic [FLIT_WIDTH-1:0]   buffer [FLITS];
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    drop_nxt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      wr_drop <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    drop_nxt   = 1'b0;
    case (state)
      FILL: begin
        if (wr_en) begin
          wr_fire = 1'b1;
          if (wr_ptr == LAST) begin
            wr_ptr_nxt = '0;
            state_nxt  = SEND;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end
      SEND: begin
        // Writes arriving while a packet is being sent are discarded.
        drop_nxt = wr_en;
        if (out_ready) begin
          rd_fire = 1'b1;
          if (rd_ptr == LAST) begin
            rd_ptr_nxt = '0;
            state_nxt  = FILL;
          end else begin
            rd_ptr_nxt = rd_ptr + 1'b1;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Reset clears the whole buffer so a discarded partial packet can never
  // resurface in a later one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < FLITS; i++) buffer[i] <= '0;
    end else if (wr_fire) begin
      buffer[wr_ptr] <= data_in;
    end
  end

  // Outputs are decoded directly from state and rd_ptr, so they follow an
  // asynchronous reset immediately and stay stable while out_ready is low.
  assign wr_ready  = (state == FILL);
  assign out_valid = (state == SEND);
  assign data_out  = out_valid ? buffer[rd_ptr] : '0;
  assign out_head  = out_valid && (rd_ptr == '0);
  assign out_tail  = out_valid && (rd_ptr == LAST);

`ifdef FLIT_PARITY_EN
  // data_out is already zero when nothing is presented, so parity is too.
  assign out_parity = ^data_out;
`endif

endmodule

// File: tb/tb_flit_reader.sv
module tb_flit_reader;
  localparam int W = 128;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         wr_ready, wr_drop, out_valid, out_head, out_tail;
  logic         out_ready = 1'b0;
  logic [W-1:0] data_out;
`ifdef FLIT_PARITY_EN
  logic         out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  flit_reader #(.FLIT_WIDTH(W), .FLITS(N)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .wr_ready  (wr_ready),
    .wr_drop   (wr_drop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_head  (out_head),
`ifdef FLIT_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_tail  (out_tail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: flits accumulate in fillq; a full packet moves to
  // sendq and is drained from the front on each accepted transfer.
  logic [W-1:0] fillq[$];
  logic [W-1:0] sendq[$];
  bit           drop_m;
  bit           rdy_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fillq.delete();
      sendq.delete();
      drop_m = 1'b0;
    end else begin
      rdy_m  = (sendq.size() == 0);
      drop_m = wr_en && !rdy_m;
      if (!rdy_m && out_ready) void'(sendq.pop_front());
      if (rdy_m && wr_en) begin
        fillq.push_back(data_in);
        if (fillq.size() == N) begin
          sendq = fillq;
          fillq.delete();
        end
      end
    end
  end

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    logic         ev;
    logic [W-1:0] ed;
    ev = (sendq.size() != 0);
    ed = ev ? sendq[0] : '0;
    chk("wr_ready",  W'(wr_ready),  W'(!ev));
    chk("out_valid", W'(out_valid), W'(ev));
    chk("data_out",  data_out,      ed);
    chk("out_head",  W'(out_head),  W'(ev && sendq.size() == N));
    chk("out_tail",  W'(out_tail),  W'(ev && sendq.size() == 1));
    chk("wr_drop",   W'(wr_drop),   W'(drop_m));
`ifdef FLIT_PARITY_EN
    chk("out_parity", W'(out_parity), W'(^ed));
`endif
  end

  // Delivered-flit log for the back-to-back scenario.
  bit           logging = 1'b0;
  logic [W-1:0] got_d[$];
  logic [1:0]   got_f[$];
  always @(negedge clk) begin
    if (logging && out_valid && out_ready) begin
      got_d.push_back(data_out);
      got_f.push_back({out_head, out_tail});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pkt(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) begin
      wr_en   = 1'b1;
      data_in = base + W'(i);
      step();
    end
    wr_en   = 1'b0;
    data_in = '0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) step();
  endtask

  initial begin
    // Reset values while reset is held
    step();
    chk("rst_wr_ready",  W'(wr_ready),  W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_data_out",  data_out,      '0);
    chk("rst_head_tail", W'({out_head, out_tail, wr_drop}), W'(0));
    rst = 1'b0;
    step();

    // Scenario 1: write 1..5 with out_ready=1
    out_ready = 1'b1;
    write_pkt(W'(1));
    chk("s1_valid_rise", W'(out_valid), W'(1));
    chk("s1_first",      data_out,      W'(1));
    chk("s1_head",       W'(out_head),  W'(1));
    chk("s1_wr_ready",   W'(wr_ready),  W'(0));
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("s1_data", data_out, W'(k));
      chk("s1_head_only_first", W'(out_head), W'(0));
    end
    chk("s1_tail", W'(out_tail), W'(1));
    step();
    chk("s1_ready_back", W'(wr_ready),  W'(1));
    chk("s1_idle_zero",  data_out,      '0);

    // Scenario 2: A0..A4 with out_ready held low for 3 cycles
    out_ready = 1'b0;
    write_pkt(W'('hA0));
    for (int k = 0; k < 3; k++) begin
      chk("s2_hold_data", data_out, W'('hA0));
      chk("s2_hold_head", W'(out_head), W'(1));
      step();
    end
    out_ready = 1'b1;
    step();
    chk("s2_after_xfer", data_out, W'('hA1));
    for (int k = 0; k < N - 1; k++) step();
    chk("s2_done", W'(wr_ready), W'(1));

    // Scenario 3: write during SEND is dropped
    out_ready = 1'b0;
    write_pkt(W'('h30));
    wr_en   = 1'b1;
    data_in = W'('hFF);
    step();
    wr_en   = 1'b0;
    data_in = '0;
    chk("s3_drop_pulse", W'(wr_drop), W'(1));
    chk("s3_data_kept",  data_out,    W'('h30));
    step();
    chk("s3_drop_one",   W'(wr_drop), W'(0));
    drain();
    chk("s3_drained", W'(wr_ready), W'(1));

    // Scenario 4: partial packet discarded by async reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      data_in = W'('h20 + i);
      step();
    end
    wr_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("s4_rst_ready", W'(wr_ready), W'(1));
    #1 rst = 1'b0;
    step();
    write_pkt(W'(10));
    chk("s4_first", data_out, W'(10));
    chk("s4_head",  W'(out_head), W'(1));
    drain();

    // Async reset mid-SEND takes effect without a clock edge
    out_ready = 1'b0;
    write_pkt(W'('h50));
    #1 rst = 1'b1;
    #1;
    chk("s4b_valid_drop", W'(out_valid), W'(0));
    chk("s4b_data_zero",  data_out,      '0);
    #1 rst = 1'b0;
    step();

    // Scenario 5: two back-to-back packets, out_ready toggling
    begin
      int nxt = 0;
      int cyc = 0;
      logging = 1'b1;
      out_ready = 1'b1;
      while (got_d.size() < 2 * N && cyc < 100) begin
        wr_en   = wr_ready && (nxt < 2 * N);
        data_in = W'('h40 + nxt);
        if (wr_en) nxt++;
        step();
        out_ready = ~out_ready;
        cyc++;
      end
      wr_en   = 1'b0;
      logging = 1'b0;
      if (got_d.size() < 2 * N) begin
        checks++;
        failures++;
        $display("FAIL s5_timeout delivered=%0d required=%0d", got_d.size(), 2 * N);
      end else begin
        for (int i = 0; i < 2 * N; i++) begin
          chk("s5_order", got_d[i], W'('h40 + i));
          chk("s5_flags", W'(got_f[i]), W'({i % N == 0, i % N == N - 1}));
        end
      end
      out_ready = 1'b1;
      while (!wr_ready && cyc < 200) begin step(); cyc++; end
    end

`ifdef FLIT_PARITY_EN
    // Scenario 6: parity of presented flits
    out_ready = 1'b0;
    wr_en = 1'b1;
    data_in = W'('h7); step();
    data_in = W'('h3); step();
    data_in = W'('h1); step();
    data_in = W'('h0); step();
    data_in = W'('h0); step();
    wr_en = 1'b0;
    chk("s6_parity7", W'(out_parity), W'(1));
    out_ready = 1'b1;
    step();
    chk("s6_parity3", W'(out_parity), W'(0));
    drain();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
